// File: rtl/cpu_ctrl_pkg.sv
// Shared control-sequencer definitions:
// state encoding, opcodes and ALU codes.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH0 = 4'd1,
    S_FETCH1 = 4'd2,
    S_FETCH2 = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;

  function automatic logic [3:0] alu_code(
    input logic [4:0] op
  );
    logic [3:0] c;
    c = ALU_NONE;
    case (op)
      OP_ADD:  c = ALU_ADD;
      OP_SUB:  c = ALU_SUB;
      OP_AND:  c = ALU_AND;
      OP_OR:   c = ALU_OR;
      default: c = ALU_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/op_decode.sv
// Opcode classifier: IR[31:27] to class flags.
// Unlisted opcodes fall into the nop class.
module op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_alu,
  output logic       is_imm,
  output logic       is_ldi,
  output logic       is_ld,
  output logic       is_st,
  output logic       is_nop,
  output logic       is_halt
);

  always_comb begin
    is_alu  = 1'b0;
    is_imm  = 1'b0;
    is_ldi  = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    unique case (1'b1)
      (opcode == OP_LD):   is_ld   = 1'b1;
      (opcode == OP_LDI):  is_ldi  = 1'b1;
      (opcode == OP_ST):   is_st   = 1'b1;
      (opcode == OP_ADD),
      (opcode == OP_SUB),
      (opcode == OP_AND),
      (opcode == OP_OR):   is_alu  = 1'b1;
      (opcode == OP_ADDI): is_imm  = 1'b1;
      (opcode == OP_HALT): is_halt = 1'b1;
      default:             is_nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch, decode and
// execute microsteps for the small CPU datapath.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic [3:0]  alu_op,
  output logic        run
);

  state_t state, state_nxt;

  logic [4:0] op;
  logic is_alu, is_imm, is_ldi;
  logic is_ld, is_st, is_nop, is_halt;
  logic is_mem, base_addr;
  logic unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^{IR[26:0], is_imm};
  assign is_mem    = is_ld | is_st;
  // Address-forming ops add the offset to a base register
  assign base_addr = is_mem | is_ldi;

  op_decode u_dec (
    .opcode  (op),
    .is_alu  (is_alu),
    .is_imm  (is_imm),
    .is_ldi  (is_ldi),
    .is_ld   (is_ld),
    .is_st   (is_st),
    .is_nop  (is_nop),
    .is_halt (is_halt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
    MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0;
    Zlowout = 1'b0; Cout = 1'b0;
    Read = 1'b0; Write = 1'b0;
    alu_op = ALU_NONE;
    run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_RST: state_nxt = S_FETCH0;
      S_FETCH0: begin
        PCout = 1'b1; MARin = 1'b1;
        IncPC = 1'b1; Zin = 1'b1;
        state_nxt = stop ? S_HALT : S_FETCH1;
      end
      S_FETCH1: begin
        Zlowout = 1'b1; PCin = 1'b1;
        Read = 1'b1; MDRin = 1'b1;
        if (mem_ready) state_nxt = S_FETCH2;
      end
      S_FETCH2: begin
        MDRout = 1'b1; IRin = 1'b1;
        unique case (1'b1)
          is_halt: state_nxt = S_HALT;
          is_nop:  state_nxt = S_FETCH0;
          default: state_nxt = S_T3;
        endcase
      end
      S_T3: begin
        Grb = 1'b1; Yin = 1'b1;
        BAout = base_addr;
        Rout  = !base_addr;
        state_nxt = S_T4;
      end
      S_T4: begin
        Zin = 1'b1;
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1;
          alu_op = alu_code(op);
        end else begin
          Cout = 1'b1;
          alu_op = ALU_ADD;
        end
        state_nxt = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_mem) begin
          MARin = 1'b1;
          state_nxt = S_T6;
        end else begin
          Gra = 1'b1; Rin = 1'b1;
          state_nxt = S_FETCH0;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (is_st) begin
          Gra = 1'b1; Rout = 1'b1;
          state_nxt = S_T7;
        end else begin
          Read = 1'b1;
          if (mem_ready) state_nxt = S_T7;
        end
      end
      S_T7: begin
        if (is_st) begin
          Write = 1'b1;
          if (mem_ready) state_nxt = S_FETCH0;
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          state_nxt = S_FETCH0;
        end
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer:
// microstep list model, vector table, random run.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset, mem_ready, stop;
  logic [31:0] IR;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic PCout, PCin, IncPC, MARin, MDRin;
  logic MDRout, IRin, Yin, Zin, Zlowout, Cout;
  logic Read, Write, run;
  logic [3:0] alu_op;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset(reset), .IR(IR),
    .mem_ready(mem_ready), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Cout(Cout),
    .Read(Read), .Write(Write),
    .alu_op(alu_op), .run(run)
  );

  wire [23:0] outs = {Gra, Grb, Grc, Rin, Rout,
    BAout, PCout, PCin, IncPC, MARin, MDRin,
    MDRout, IRin, Yin, Zin, Zlowout, Cout,
    Read, Write, run, alu_op};

  localparam logic [23:0] B_GRA  = 24'd1 << 23;
  localparam logic [23:0] B_GRB  = 24'd1 << 22;
  localparam logic [23:0] B_GRC  = 24'd1 << 21;
  localparam logic [23:0] B_RIN  = 24'd1 << 20;
  localparam logic [23:0] B_ROUT = 24'd1 << 19;
  localparam logic [23:0] B_BA   = 24'd1 << 18;
  localparam logic [23:0] B_PCO  = 24'd1 << 17;
  localparam logic [23:0] B_PCI  = 24'd1 << 16;
  localparam logic [23:0] B_INC  = 24'd1 << 15;
  localparam logic [23:0] B_MAR  = 24'd1 << 14;
  localparam logic [23:0] B_MDRI = 24'd1 << 13;
  localparam logic [23:0] B_MDRO = 24'd1 << 12;
  localparam logic [23:0] B_IRIN = 24'd1 << 11;
  localparam logic [23:0] B_YIN  = 24'd1 << 10;
  localparam logic [23:0] B_ZIN  = 24'd1 << 9;
  localparam logic [23:0] B_ZLO  = 24'd1 << 8;
  localparam logic [23:0] B_COUT = 24'd1 << 7;
  localparam logic [23:0] B_RD   = 24'd1 << 6;
  localparam logic [23:0] B_WR   = 24'd1 << 5;
  localparam logic [23:0] B_RUN  = 24'd1 << 4;

  int total = 0;
  int passed = 0;
  logic [23:0] got;

  // Reference: position within the instruction's
  // microstep list, plus reset/halt flags.
  int   m_pos = 0;
  logic m_rst = 1'b1;
  logic m_halt = 1'b0;
  logic [31:0] cur_ir = '0;

  function automatic int kind(input logic [4:0] op);
    case (op)
      5'b00000: return 1;
      5'b00001: return 2;
      5'b00010: return 3;
      5'b00011, 5'b00100,
      5'b00101, 5'b00110: return 4;
      5'b01100: return 5;
      5'b11011: return 6;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu(input logic [4:0] op);
    case (op)
      5'b00011: return 4'd1;
      5'b00100: return 4'd2;
      5'b00101: return 4'd3;
      5'b00110: return 4'd4;
      default:  return 4'd0;
    endcase
  endfunction

  function automatic int seq_len(input logic [4:0] op);
    int k;
    k = kind(op);
    if (k == 0 || k == 6) return 3;
    if (k == 1 || k == 3) return 8;
    return 6;
  endfunction

  function automatic logic [24:0] word(input int p, input logic [4:0] op);
    logic [23:0] c;
    logic w;
    int k;
    k = kind(op);
    c = '0;
    w = 1'b0;
    case (p)
      0: c = B_PCO | B_MAR | B_INC | B_ZIN;
      1: begin c = B_ZLO | B_PCI | B_RD | B_MDRI; w = 1'b1; end
      2: c = B_MDRO | B_IRIN;
      3: c = (k == 1 || k == 2 || k == 3) ?
             (B_GRB | B_BA | B_YIN) : (B_GRB | B_ROUT | B_YIN);
      4: c = (k == 4) ?
             (B_GRC | B_ROUT | B_ZIN | {20'd0, exp_alu(op)}) :
             (B_COUT | B_ZIN | 24'd1);
      5: c = (k == 1 || k == 3) ?
             (B_ZLO | B_MAR) : (B_ZLO | B_GRA | B_RIN);
      6: if (k == 3) c = B_GRA | B_ROUT | B_MDRI;
         else begin c = B_RD | B_MDRI; w = 1'b1; end
      7: if (k == 3) begin c = B_WR; w = 1'b1; end
         else c = B_MDRO | B_GRA | B_RIN;
      default: c = '0;
    endcase
    return {w, c | B_RUN};
  endfunction

  function automatic logic [23:0] model_out();
    logic [24:0] wd;
    if (m_rst || m_halt) return '0;
    wd = word(m_pos, cur_ir[31:27]);
    return wd[23:0];
  endfunction

  task automatic model_step(input logic r, input logic s,
                            input logic rdy, input logic [31:0] ir);
    logic [24:0] wd;
    wd = word(m_pos, ir[31:27]);
    if (r) begin
      m_rst = 1'b1; m_halt = 1'b0; m_pos = 0;
    end else if (m_rst) begin
      m_rst = 1'b0; m_pos = 0;
    end else if (m_halt) begin
    end else if (m_pos == 0 && s) begin
      m_halt = 1'b1;
    end else if (wd[24] && !rdy) begin
    end else if (m_pos == 2 && kind(ir[31:27]) == 6) begin
      m_halt = 1'b1;
    end else begin
      m_pos = m_pos + 1;
      if (m_pos >= seq_len(ir[31:27])) m_pos = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [23:0] a,
                     input logic [23:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, a, e);
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, a, e);
  endtask

  task automatic sample();
    @(negedge clk);
    got = outs;
    chk("outputs", got, model_out());
    chk_int("bus_onehot", int'($onehot0({got[19], got[18],
            got[17], got[12], got[8], got[7]})), 1);
    chk_int("gr_onehot", int'($onehot0(got[23:21])), 1);
  endtask

  task automatic drive(input logic r, input logic s,
                       input logic rdy, input logic [31:0] ir);
    reset = r; stop = s; mem_ready = rdy; IR = ir;
    model_step(r, s, rdy, ir);
    cur_ir = ir;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, cur_ir);
    sample();
    chk("rst_zero", got, 24'd0);
    drive(1'b0, 1'b0, 1'b0, cur_ir);
    sample();
    chk_int("rst_fetch0", int'(got[17]), 1);
  endtask

  // Starts with FETCH0 sampled, ends with next FETCH0 sampled.
  task automatic run_one(input logic [4:0] op, input int fw, input int ew,
                         output int cyc, output int fr, output int er,
                         output int wr, output logic [3:0] alu);
    logic [31:0] ir;
    logic seen_ir, rdy;
    ir = {op, 27'($urandom)};
    cyc = 1; fr = 0; er = 0; wr = 0; alu = 4'd0;
    seen_ir = 1'b0;
    drive(1'b0, 1'b0, 1'($urandom), ir);
    for (int i = 0; i < 40; i++) begin
      sample();
      if (got[17]) return;
      cyc++;
      if (got[11]) seen_ir = 1'b1;
      if (got[3:0] != 4'd0) alu = got[3:0];
      rdy = 1'($urandom);
      if (got[6] && !seen_ir) begin fr++; rdy = fr > fw; end
      else if (got[6]) begin er++; rdy = er > ew; end
      else if (got[5]) begin wr++; rdy = wr > ew; end
      drive(1'b0, 1'b0, rdy, ir);
    end
    total++;
    $display("FAIL run_one_timeout op=%b cycles=%0d", op, cyc);
  endtask

  typedef struct {
    logic [4:0] op;
    int         cyc;
    logic [3:0] alu;
  } vec_t;

  vec_t vecs[11];
  logic [4:0] ops[11];

  initial begin
    int cyc, fr, er, wr, n;
    logic [3:0] alu;
    logic [31:0] ir;
    logic r, s;

    vecs[0]  = '{5'b00000, 8, 4'd1};
    vecs[1]  = '{5'b00001, 6, 4'd1};
    vecs[2]  = '{5'b00010, 8, 4'd1};
    vecs[3]  = '{5'b00011, 6, 4'd1};
    vecs[4]  = '{5'b00100, 6, 4'd2};
    vecs[5]  = '{5'b00101, 6, 4'd3};
    vecs[6]  = '{5'b00110, 6, 4'd4};
    vecs[7]  = '{5'b01100, 6, 4'd1};
    vecs[8]  = '{5'b11010, 3, 4'd0};
    vecs[9]  = '{5'b10101, 3, 4'd0};
    vecs[10] = '{5'b11111, 3, 4'd0};
    foreach (vecs[i]) ops[i] = vecs[i].op;

    reset = 1'b1; stop = 1'b0; mem_ready = 1'b0; IR = '0;
    sample();
    chk("reset_state", got, 24'd0);
    drive(1'b0, 1'b0, 1'b0, '0);
    sample();
    chk("first_fetch0", got, B_PCO | B_MAR | B_INC | B_ZIN | B_RUN);

    foreach (vecs[i]) begin
      run_one(vecs[i].op, 0, 0, cyc, fr, er, wr, alu);
      chk_int($sformatf("len_%b", vecs[i].op), cyc, vecs[i].cyc);
      chk_int($sformatf("alu_%b", vecs[i].op), int'(alu), int'(vecs[i].alu));
    end

    run_one(5'b00000, 3, 2, cyc, fr, er, wr, alu);
    chk_int("ld_fetch_read", fr, 4);
    chk_int("ld_t6_read", er, 3);
    chk_int("ld_total", cyc, 13);

    run_one(5'b00010, 0, 3, cyc, fr, er, wr, alu);
    chk_int("st_write_hold", wr, 4);
    chk_int("st_total", cyc, 11);

    // Reset during the T6 read wait
    ir = {5'b00000, 27'd0};
    drive(1'b0, 1'b0, 1'b1, ir);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      sample();
      if (got[6] && got[3:0] == 4'd0 && !got[16]) n++;
      drive(1'b0, 1'b0, n == 0, ir);
    end
    chk_int("t6_wait_reached", n, 2);
    do_reset();

    // halt opcode then ignored activity
    drive(1'b0, 1'b0, 1'b1, {5'b11011, 27'd0});
    for (int i = 0; i < 3; i++) begin
      sample();
      drive(1'b0, 1'b0, 1'b1, {5'b11011, 27'd0});
    end
    chk_int("halt_run", int'(run), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), $urandom);
      sample();
      chk("halt_hold", got, 24'd0);
    end
    do_reset();

    // stop sampled in FETCH0
    drive(1'b0, 1'b1, 1'b1, {5'b00011, 27'd0});
    sample();
    chk_int("stop_run", int'(run), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'($urandom), $urandom);
      sample();
      chk("stop_hold", got, 24'd0);
    end
    do_reset();

    // Random traffic against the microstep model
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom % 150 == 0) || (m_halt && $urandom % 6 == 0);
      s = ($urandom % 40 == 0);
      ir = cur_ir;
      if (m_pos == 0 && !m_halt) begin
        ir = $urandom;
        if ($urandom % 4 != 0)
          ir[31:27] = ops[$urandom % 11];
        else if ($urandom % 8 == 0)
          ir[31:27] = 5'b11011;
      end
      drive(r, s, 1'($urandom), ir);
      sample();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL have input IR  in  32  current instruction; opcode is IR[31:27].
REQ-003 The block SHALL have input mem_ready  in  1  memory has completed the current Read or Write.
REQ-004 The block SHALL have input stop  in  1  halt request, sampled only in FETCH0.
REQ-005 The block SHALL have outputs Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/encode controls.
REQ-006 The block SHALL have outputs PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout  out  1 each  datapath strobes.
REQ-007 The block SHALL have outputs Read, Write  out  1 each  memory request, held until mem_ready.
REQ-008 The block SHALL have output alu_op  out  4  ALU operation code: ADD=0001, SUB=0010, AND=0011, OR=0100, NONE=0000.
REQ-009 The block SHALL have output run  out  1  high in every state except RST and HALT.

Function
REQ-010 The block SHALL implement a Moore FSM; every output SHALL be a pure function of the current state and IR[31:27].
REQ-011 The FSM states SHALL be RST, FETCH0, FETCH1, FETCH2, T3, T4, T5, T6, T7 and HALT.
REQ-012 Opcodes SHALL be ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, nop=11010, halt=11011; any other opcode SHALL execute as nop.
REQ-013 RST SHALL drive all outputs to 0 and SHALL advance to FETCH0 on the first clock with reset low.
REQ-014 In FETCH0, stop=1 SHALL transition to HALT; otherwise FETCH0 SHALL assert PCout, MARin, IncPC and Zin, then advance to FETCH1.
REQ-015 FETCH1 SHALL assert Zlowout, PCin, Read and MDRin; it SHALL remain in FETCH1 while mem_ready=0 and advance to FETCH2 when mem_ready=1.
REQ-016 FETCH2 SHALL assert MDRout and IRin; the next state SHALL be FETCH0 for nop or unknown opcodes, HALT for halt, and T3 otherwise.
REQ-017 For add/sub/and/or: T3 SHALL assert Grb, Rout, Yin; T4 SHALL assert Grc, Rout, Zin with alu_op set per opcode; T5 SHALL assert Zlowout, Gra, Rin, then go to FETCH0.
REQ-018 For addi: T3 SHALL assert Grb, Rout, Yin; T4 SHALL assert Cout, Zin with alu_op=ADD; T5 SHALL assert Zlowout, Gra, Rin, then go to FETCH0.
REQ-019 For ldi: T3 SHALL assert Grb, BAout, Yin; T4 SHALL assert Cout, Zin with alu_op=ADD; T5 SHALL assert Zlowout, Gra, Rin, then go to FETCH0.
REQ-020 For ld/st: T3 SHALL assert Grb, BAout, Yin; T4 SHALL assert Cout, Zin with alu_op=ADD; T5 SHALL assert Zlowout, MARin.
REQ-021 For ld: T6 SHALL assert Read and MDRin, waiting on mem_ready; T7 SHALL assert MDRout, Gra, Rin, then go to FETCH0.
REQ-022 For st: T6 SHALL assert Gra, Rout, MDRin; T7 SHALL assert Write, waiting on mem_ready, then go to FETCH0.
REQ-023 At most one of Gra/Grb/Grc SHALL be high in any state, and at most one bus driver (Rout, BAout, PCout, MDRout, Zlowout, Cout) SHALL be high in any state.
REQ-024 HALT SHALL hold all outputs at 0, including run, until reset.
REQ-025 A mem_ready pulse arriving in any non-waiting state SHALL be ignored.

Reset
REQ-026 reset=1 sampled on a rising clk edge SHALL force the FSM to RST from any state, including mid-fetch and mid-memory-wait; Read and Write SHALL deassert in the cycle after that edge.
REQ-027 No output SHALL depend asynchronously on reset.

Structure
REQ-028 The opcode constants, alu_op codes and state encoding SHALL reside in a shared package, cpu_ctrl_pkg.
REQ-029 Opcode classification SHALL be implemented in one sub-module, op_decode, which maps IR[31:27] to the class flags is_alu, is_imm, is_ldi, is_ld, is_st, is_nop and is_halt.

Verification
REQ-030 Reset, then mem_ready tied 1 and IR=add (opcode 00011): the bench SHALL see FETCH0..T5 in 6 cycles, with Grb+Rout+Yin, then Grc+Rout+Zin with alu_op=0001, then Gra+Rin+Zlowout.
REQ-031 ld with mem_ready low for 3 cycles in FETCH1 and 2 cycles in T6: Read SHALL be held 4 cycles and 3 cycles respectively, and the total instruction SHALL take 13 cycles.
REQ-032 st: T6 SHALL show Gra+Rout+MDRin; T7 SHALL hold Write until mem_ready=1, then return to FETCH0.
REQ-033 halt opcode, and separately stop=1 in FETCH0: the bench SHALL see HALT with run=0; further mem_ready and IR changes SHALL cause no output change.
REQ-034 Reset asserted while in the T6 Read wait: the bench SHALL see RST with all outputs 0 in the next cycle, then FETCH0 with PCout=1 one cycle after reset is released.
REQ-035 Every state/opcode pair: an assertion SHALL check the one-hot bus-driver rule and the Gra/Grb/Grc exclusivity rule.
